mult_arb_ctrl: RTL and testbench

MULT_ARB_CTRL -- requirements
Module: mult_arb_ctrl

---
 rtl/mult_arb_ctrl.sv | 85 ++++++++
 tb/tb_mult_arb_ctrl.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/mult_arb_ctrl.sv
// Two-requester round-robin arbiter and sequencer for a shared 8-bit shift-add multiplier.
// One job: LOAD, then 8 ADD/SHIFT pairs, then a one-cycle DONE back to the owner.
module mult_arb_ctrl (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Req0,
  input  logic       Req1,
  input  logic       M,
  output logic       Grant0,
  output logic       Grant1,
  output logic       Sel,
  output logic       Clr_Ld,
  output logic       Clear_A,
  output logic       Add,
  output logic       Sub,
  output logic       Shift,
  output logic       Done0,
  output logic       Done1,
  output logic       Busy,
  output logic [2:0] state_dbg
);

  // Handshake: a requester holds Req high until its one-cycle Done pulse; Grant/Sel mark
  // datapath ownership for the whole job, and Req changes inside a job are not looked at.
  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] LOAD  = 3'd1;
  localparam logic [2:0] ADD   = 3'd2;
  localparam logic [2:0] SHIFT = 3'd3;
  localparam logic [2:0] DONE  = 3'd4;

  logic [2:0] state;
  logic [2:0] state_nxt;
  logic [2:0] cnt;
  logic       last;
  logic       owner;
  logic       any_req;

  assign any_req = Req0 | Req1;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_req) state_nxt = LOAD;
      LOAD:    state_nxt = ADD;
      ADD:     state_nxt = SHIFT;
      SHIFT:   state_nxt = (cnt == 3'd7) ? DONE : ADD;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= IDLE;
      cnt   <= 3'd0;
      last  <= 1'b1;
      owner <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        // On contention the requester not served last wins.
        IDLE:  if (any_req) owner <= (Req0 & Req1) ? ~last : Req1;
        LOAD:  cnt <= 3'd0;
        SHIFT: if (cnt != 3'd7) cnt <= cnt + 3'd1;
        DONE:  last <= owner;
        default: ;
      endcase
    end
  end

  assign Busy      = (state != IDLE);
  assign Grant0    = Busy & ~owner;
  assign Grant1    = Busy & owner;
  assign Sel       = Busy & owner;
  assign Clr_Ld    = (state == LOAD);
  assign Clear_A   = (state == LOAD);
  // The last partial product carries the multiplier sign, so it is subtracted.
  assign Add       = (state == ADD) & M;
  assign Sub       = (state == ADD) & (cnt == 3'd7) & M;
  assign Shift     = (state == SHIFT);
  assign Done0     = (state == DONE) & ~owner;
  assign Done1     = (state == DONE) & owner;
  assign state_dbg = state;

endmodule

// File: tb/tb_mult_arb_ctrl.sv
// Bench for mult_arb_ctrl: job-phase model checked every cycle, done-order scoreboard,
// and hand-computed pulse counts / latencies for directed jobs.
module tb_mult_arb_ctrl;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic       Req0 = 1'b0;
  logic       Req1 = 1'b0;
  logic       M = 1'b0;
  logic       Grant0, Grant1, Sel, Clr_Ld, Clear_A, Add, Sub, Shift, Done0, Done1, Busy;
  logic [2:0] state_dbg;

  mult_arb_ctrl dut (
    .Clk(Clk), .Reset(Reset), .Req0(Req0), .Req1(Req1), .M(M),
    .Grant0(Grant0), .Grant1(Grant1), .Sel(Sel), .Clr_Ld(Clr_Ld), .Clear_A(Clear_A),
    .Add(Add), .Sub(Sub), .Shift(Shift), .Done0(Done0), .Done1(Done1), .Busy(Busy),
    .state_dbg(state_dbg)
  );

  // ---------------- clock ----------------
  always #5 Clk = ~Clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- model: job phase 1..18 (1 = load, 2..17 add/shift, 18 = done) ----------------
  logic       m_busy  = 1'b0;
  logic       m_owner = 1'b0;
  logic       m_last  = 1'b1;
  int         m_phase = 0;
  logic [7:0] m_pat   = 8'hFF;

  function automatic logic is_add_phase(input logic b, input int ph);
    return b && ph >= 2 && ph <= 16 && (ph % 2 == 0);
  endfunction

  always @(posedge Clk) begin
    if (Reset) begin
      m_busy = 1'b0; m_phase = 0; m_last = 1'b1; m_owner = 1'b0;
    end else if (!m_busy) begin
      if (Req0 || Req1) begin
        m_busy  = 1'b1;
        m_phase = 1;
        m_owner = (Req0 && Req1) ? !m_last : Req1;
      end
    end else if (m_phase == 18) begin
      m_busy = 1'b0; m_phase = 0; m_last = m_owner;
    end else begin
      m_phase++;
    end
    #1;
    if (is_add_phase(m_busy, m_phase)) M = m_pat[(m_phase - 2) / 2];
    else M = 1'($urandom_range(0, 1));
  end

  // ---------------- scoreboard + per-cycle compare ----------------
  logic exp_q[$];
  logic [10:0] exp_v, act_v;
  logic        add_ph, prev_g = 1'b0;
  int cyc = 0, run = 0, last_done_run = 0, last_rise = 0, prev_rise = 0;
  int cnt_add = 0, cnt_sub = 0, cnt_shift = 0, cnt_clr = 0, cnt_done = 0;

  always @(negedge Clk) begin
    cyc++;
    add_ph = is_add_phase(m_busy, m_phase);
    exp_v = {m_busy && !m_owner, m_busy && m_owner, m_busy && m_owner,
             m_busy && m_phase == 1, m_busy && m_phase == 1,
             add_ph && M, add_ph && M && ((m_phase - 2) / 2 == 7),
             m_busy && m_phase >= 3 && m_phase <= 17 && (m_phase % 2 == 1),
             m_busy && m_phase == 18 && !m_owner, m_busy && m_phase == 18 && m_owner,
             m_busy};
    act_v = {Grant0, Grant1, Sel, Clr_Ld, Clear_A, Add, Sub, Shift, Done0, Done1, Busy};
    check("outputs", 32'(act_v), 32'(exp_v));
    if (Grant0 || Grant1) run++; else run = 0;
    if ((Grant0 || Grant1) && !prev_g) begin prev_rise = last_rise; last_rise = cyc; end
    prev_g = Grant0 || Grant1;
    cnt_add   += int'(Add);
    cnt_sub   += int'(Sub);
    cnt_shift += int'(Shift);
    cnt_clr   += int'(Clr_Ld);
    if (Done0 || Done1) begin
      cnt_done++;
      last_done_run = run;
      if (exp_q.size() == 0) check("done_unexpected", 32'(Done1), 32'hFFFF_FFFF);
      else check("done_owner", 32'(Done1), 32'(exp_q.pop_front()));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge Clk); #1;
  endtask

  // Returns #1 after the edge following the n-th Done pulse (DUT is then idle).
  task automatic wait_dones(input int n, input int budget);
    int seen = 0;
    for (int i = 0; i < budget && seen < n; i++) begin
      @(negedge Clk);
      if (Done0 || Done1) seen++;
    end
    check("done_timeout", 32'(seen), 32'(n));
    step();
  endtask

  int s_add, s_sub, s_shift, s_clr, s_done, nsh;

  task automatic snap();
    s_add = cnt_add; s_sub = cnt_sub; s_shift = cnt_shift; s_clr = cnt_clr; s_done = cnt_done;
  endtask

  // ---------------- directed tests ----------------
  initial begin
    repeat (3) step();
    check("reset_outputs", 32'({Grant0, Grant1, Sel, Clr_Ld, Clear_A, Add, Sub, Shift, Done0, Done1, Busy}), 32'd0);
    Reset = 1'b0;
    step();

    // Single requester 0, M=1 every cycle.
    m_pat = 8'hFF; snap(); exp_q.push_back(1'b0); Req0 = 1'b1;
    wait_dones(1, 40); Req0 = 1'b0;
    check("a_busy_after", 32'(Busy), 32'd0);
    check("a_add_cnt", 32'(cnt_add - s_add), 32'd8);
    check("a_shift_cnt", 32'(cnt_shift - s_shift), 32'd8);
    check("a_sub_cnt", 32'(cnt_sub - s_sub), 32'd1);
    check("a_clr_cnt", 32'(cnt_clr - s_clr), 32'd1);
    check("a_latency", 32'(last_done_run), 32'd18);
    step();

    // Alternating multiplier bits 1,0,1,0...: Add on ADD 1,3,5,7; no Sub.
    m_pat = 8'h55; snap(); exp_q.push_back(1'b0); Req0 = 1'b1;
    wait_dones(1, 40); Req0 = 1'b0;
    check("b_add_cnt", 32'(cnt_add - s_add), 32'd4);
    check("b_sub_cnt", 32'(cnt_sub - s_sub), 32'd0);
    step();

    // Requester 1 alone, bits 1,1,0,0,0,1,0,1 -> 4 adds, last one subtracts.
    m_pat = 8'hA3; snap(); exp_q.push_back(1'b1); Req1 = 1'b1;
    wait_dones(1, 40); Req1 = 1'b0;
    check("c_add_cnt", 32'(cnt_add - s_add), 32'd4);
    check("c_sub_cnt", 32'(cnt_sub - s_sub), 32'd1);
    check("c_latency", 32'(last_done_run), 32'd18);
    step();

    // Both requesting from reset: 0,1,0,1 with 19-cycle grant spacing.
    Reset = 1'b1; step(); step(); Reset = 1'b0;
    m_pat = 8'hFF; Req0 = 1'b1; Req1 = 1'b1;
    exp_q.push_back(1'b0); exp_q.push_back(1'b1); exp_q.push_back(1'b0); exp_q.push_back(1'b1);
    wait_dones(4, 100); Req0 = 1'b0; Req1 = 1'b0;
    check("rr_spacing", 32'(last_rise - prev_rise), 32'd19);
    step();

    // Same requester held high is served again.
    exp_q.push_back(1'b0); exp_q.push_back(1'b0); Req0 = 1'b1;
    wait_dones(2, 60); Req0 = 1'b0;
    check("rehold_spacing", 32'(last_rise - prev_rise), 32'd19);
    step();

    // Reset in the 5th SHIFT cycle aborts without a Done.
    Req0 = 1'b1; nsh = 0;
    for (int i = 0; i < 40 && nsh < 5; i++) begin
      @(negedge Clk);
      if (Shift) nsh++;
    end
    check("abort_shift_seen", 32'(nsh), 32'd5);
    Reset = 1'b1; Req0 = 1'b0;
    step();
    check("abort_outputs", 32'({Grant0, Grant1, Sel, Clr_Ld, Clear_A, Add, Sub, Shift, Done0, Done1, Busy}), 32'd0);
    Reset = 1'b0; snap();
    repeat (20) step();
    check("abort_no_done", 32'(cnt_done - s_done), 32'd0);
    exp_q.push_back(1'b0); Req0 = 1'b1;
    wait_dones(1, 40); Req0 = 1'b0;
    check("abort_next_latency", 32'(last_done_run), 32'd18);
    step();

    // Requester 1 drops its request early; requester 0 blips during the job.
    exp_q.push_back(1'b1); Req1 = 1'b1;
    repeat (3) step();
    Req1 = 1'b0; Req0 = 1'b1;
    repeat (2) step();
    Req0 = 1'b0;
    wait_dones(1, 40);
    check("drop_latency", 32'(last_done_run), 32'd18);
    check("drop_busy_after", 32'(Busy), 32'd0);
    repeat (3) step();

    check("exp_q_empty", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
